// File: rtl/pc_sequencer.sv
// Purpose : program counter with next-PC select, hardware return-address stack and run/halt/fault sequencing.
// Latency : control sampled on cycle N is reflected on pc and the status outputs in cycle N+1 (all outputs registered).
// Backpressure: stall=1 in RUN freezes pc, stack and state; there is no backpressure toward the decoder.
//
// Ports:
//   Clk, Reset (async, active-low)   clock / reset
//   start                            IDLE->RUN request
//   stall                            hold everything this cycle (RUN only)
//   halt, jump, call, ret, taken     decoded flow control for the instruction at pc
//   target                           jump/call destination
//   pc, pc_valid                     fetch address and its qualifier (state RUN)
//   done, fault                      state HALT / state FAULT
//   stack_ovf, stack_unf             sticky stack error flags
//   cycle_cnt                        unstalled RUN cycle counter
// Optional feature: define PC_SEQ_CYCLE_CNT_EN to build the saturating cycle counter;
// without it cycle_cnt is tied to zero and no counter flops exist.
module pc_sequencer #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4,
    parameter int START_ADDR  = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start,
    input  logic            stall,
    input  logic            halt,
    input  logic            jump,
    input  logic            call,
    input  logic            ret,
    input  logic            taken,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            done,
    output logic            fault,
    output logic            stack_ovf,
    output logic            stack_unf,
    output logic [31:0]     cycle_cnt
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [PC_W-1:0]   stack_q [STACK_DEPTH];
    logic              push;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              pc_valid_q, pc_valid_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;

    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   stack_top;
    logic              stack_empty;
    logic              stack_full;

    // Natural wrap at 2**PC_W; the pushed return address wraps the same way.
    assign pc_inc      = pc_q + PC_W'(1);
    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));

    // Top of stack is entry sp-1; decoded by compare to avoid out-of-range indexing.
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                stack_top = stack_q[i];
            end
        end
    end

    // Next-state / datapath select. Priority in RUN: halt, ret, call, jump&taken, increment.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        push    = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = PC_W'(START_ADDR);
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_d = S_HALT;
                    end else if (ret) begin
                        if (stack_empty) begin
                            state_d = S_FAULT;
                            unf_d   = 1'b1;
                        end else begin
                            pc_d = stack_top;
                            sp_d = sp_q - SP_W'(1);
                        end
                    end else if (call) begin
                        if (stack_full) begin
                            state_d = S_FAULT;
                            ovf_d   = 1'b1;
                        end else begin
                            push = 1'b1;
                            pc_d = target;
                            sp_d = sp_q + SP_W'(1);
                        end
                    end else if (jump && taken) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: ; // HALT and FAULT are absorbing
        endcase
    end

    // Output decode of the next state, registered so outputs have no comb path from inputs.
    always_comb begin
        pc_valid_d = (state_d == S_RUN);
        done_d     = (state_d == S_HALT);
        fault_d    = (state_d == S_FAULT);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_W'(START_ADDR);
            sp_q       <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            pc_valid_q <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            pc_valid_q <= pc_valid_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (push && (sp_q == SP_W'(i))) begin
                    stack_q[i] <= pc_inc;
                end
            end
        end
    end

`ifdef PC_SEQ_CYCLE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Counts every unstalled RUN cycle, including the one that halts or faults.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == S_RUN) && !stall && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = 32'h0;
`endif

    assign pc        = pc_q;
    assign pc_valid  = pc_valid_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : self-checking bench for pc_sequencer against a queue-based behavioural model.
// Latency : each stimulus cycle is checked 1 time unit after the rising edge that consumes it.
// Backpressure: stall is exercised in directed and random phases.
module tb_pc_sequencer;

    localparam int PC_W   = 10;
    localparam int DEPTH  = 4;
    localparam int START  = 0;
    localparam int MOD    = 1 << PC_W;

    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            start, stall, halt, jump, call, ret, taken;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
    logic            pc_valid, done, fault, stack_ovf, stack_unf;
    logic [31:0]     cycle_cnt;

    pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .START_ADDR(START)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .stall     (stall),
        .halt      (halt),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .taken     (taken),
        .target    (target),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .done      (done),
        .fault     (fault),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf),
        .cycle_cnt (cycle_cnt)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    int     m_state;
    int     m_pc;
    int     m_stk [$];
    bit     m_ovf, m_unf;
    longint m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef PC_SEQ_CYCLE_CNT_EN
        return m_cnt[31:0];
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = START;
        m_stk.delete();
        m_ovf   = 0;
        m_unf   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        if (m_state == M_IDLE) begin
            if (start) begin
                m_state = M_RUN;
                m_pc    = START;
            end
        end else if (m_state == M_RUN && !stall) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (halt) begin
                m_state = M_HALT;
            end else if (ret) begin
                if (m_stk.size() == 0) begin
                    m_state = M_FAULT;
                    m_unf   = 1;
                end else begin
                    m_pc = m_stk.pop_back();
                end
            end else if (call) begin
                if (m_stk.size() == DEPTH) begin
                    m_state = M_FAULT;
                    m_ovf   = 1;
                end else begin
                    m_stk.push_back((m_pc + 1) % MOD);
                    m_pc = int'(target);
                end
            end else if (jump && taken) begin
                m_pc = int'(target);
            end else begin
                m_pc = (m_pc + 1) % MOD;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},       32'(pc),        32'(m_pc));
        check({tag, ".pc_valid"}, 32'(pc_valid),  32'(m_state == M_RUN));
        check({tag, ".done"},     32'(done),      32'(m_state == M_HALT));
        check({tag, ".fault"},    32'(fault),     32'(m_state == M_FAULT));
        check({tag, ".ovf"},      32'(stack_ovf), 32'(m_ovf));
        check({tag, ".unf"},      32'(stack_unf), 32'(m_unf));
        check({tag, ".cnt"},      cycle_cnt,      exp_cnt());
    endtask

    task automatic set_in(input logic st, input logic stl, input logic hl, input logic jp,
                          input logic cl, input logic rt, input logic tk, input int tgt);
        start  = st;  stall = stl; halt = hl; jump = jp;
        call   = cl;  ret   = rt;  taken = tk;
        target = PC_W'(tgt);
    endtask

    // One clock: inputs already driven, model follows the same edge, compare 1 unit later.
    task automatic cycle(input string tag);
        @(posedge Clk);
        model_step();
        #1;
        check_all(tag);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic plain(input string tag);           set_in(0,0,0,0,0,0,0,$urandom_range(MOD-1)); cycle(tag); endtask
    task automatic do_start(input string tag);        set_in(1,0,0,0,0,0,0,0);       cycle(tag); endtask
    task automatic do_jump(input int t, input logic tk, input string tag); set_in(0,0,0,1,0,0,tk,t); cycle(tag); endtask
    task automatic do_call(input int t, input string tag); set_in(0,0,0,1,1,0,1,t); cycle(tag); endtask
    task automatic do_ret(input string tag);          set_in(0,0,0,1,0,1,1,0);       cycle(tag); endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        check_all("reset_init");
        @(negedge Clk);
        Reset = 1'b1;

        // IDLE ignores everything but start
        set_in(0, 0, 1, 1, 1, 1, 1, 9);
        cycle("idle_ignore");

        // 1: reset mid-RUN at pc=0x05 with two entries stacked
        do_start("t1_start");
        do_call(3, "t1_call0");
        do_call(5, "t1_call1");
        check("t1_pc_before", 32'(pc), 32'h5);
        do_reset("t1_reset");
        check("t1_pc", 32'(pc), 32'h0);
        check("t1_valid", 32'(pc_valid), 32'h0);
        do_start("t1_restart");
        do_ret("t1_ret_empty");          // stack cleared by reset -> underflow
        check("t1_sp0_unf", 32'(stack_unf), 32'h1);

        // 2: sequential, jump taken, jump not taken
        do_reset("t2_reset");
        do_start("t2_start");
        plain("t2_p1"); plain("t2_p2"); plain("t2_p3");
        check("t2_pc3", 32'(pc), 32'h3);
        do_jump('h040, 1, "t2_jt");
        check("t2_pc40", 32'(pc), 32'h040);
        do_jump('h123, 0, "t2_jnt");
        check("t2_pc41", 32'(pc), 32'h041);

        // 3: call / ret round trip
        do_jump('h010, 1, "t3_to10");
        do_call('h100, "t3_call");
        check("t3_pc100", 32'(pc), 32'h100);
        plain("t3_s1"); plain("t3_s2");
        do_ret("t3_ret");
        check("t3_pc11", 32'(pc), 32'h011);
        set_in(0, 0, 0, 0, 1, 1, 0, 'h2AA); // call+ret together: ret wins, stack empty
        cycle("t3_callret");
        check("t3_unf", 32'(stack_unf), 32'h1);
        check("t3_noovf", 32'(stack_ovf), 32'h0);

        // 4: overflow on the fifth nested call, then underflow in a fresh run
        do_reset("t4_reset");
        do_start("t4_start");
        for (int i = 0; i < 5; i++) do_call(32 * (i + 1), $sformatf("t4_call%0d", i));
        check("t4_fault", 32'(fault), 32'h1);
        check("t4_ovf", 32'(stack_ovf), 32'h1);
        check("t4_pc_held", 32'(pc), 32'(4 * 32));
        do_start("t4_start_ignored");
        plain("t4_absorb");
        do_reset("t4_reset2");
        do_start("t4_start2");
        do_ret("t4_unf");
        check("t4_unf_flag", 32'(stack_unf), 32'h1);
        check("t4_unf_fault", 32'(fault), 32'h1);

        // 5: pc wrap, wrapped return address, stall freezes a call
        do_reset("t5_reset");
        do_start("t5_start");
        do_jump('h3FF, 1, "t5_to3ff");
        plain("t5_wrap");
        check("t5_pc0", 32'(pc), 32'h0);
        do_jump('h3FF, 1, "t5_to3ff_b");
        do_call('h020, "t5_call");
        set_in(0, 1, 0, 1, 1, 0, 1, 'h155);
        cycle("t5_stall_call");
        check("t5_stall_pc", 32'(pc), 32'h020);
        do_ret("t5_ret");
        check("t5_ret_pc0", 32'(pc), 32'h0);
        check("t5_no_fault", 32'(fault), 32'h0);

        // 6: halt after 7 unstalled cycles plus 2 stalls
        do_reset("t6_reset");
        do_start("t6_start");
        for (int i = 0; i < 9; i++) begin
            set_in(0, (i == 2 || i == 5), (i == 2 || i == 5), 0, 0, 0, 0, 0); // stalled halt ignored
            cycle($sformatf("t6_c%0d", i));
        end
        set_in(0, 0, 1, 0, 0, 0, 0, 0);
        cycle("t6_halt");
        check("t6_done", 32'(done), 32'h1);
`ifdef PC_SEQ_CYCLE_CNT_EN
        check("t6_cnt", cycle_cnt, 32'd8);
`else
        check("t6_cnt", cycle_cnt, 32'd0);
`endif
        do_start("t6_start_ignored");
        check("t6_still_done", 32'(done), 32'h1);

        // Randomised runs against the model
        for (int run = 0; run < 6; run++) begin
            do_reset($sformatf("r%0d_reset", run));
            do_start($sformatf("r%0d_start", run));
            for (int c = 0; c < 250; c++) begin
                int r;
                if (m_state != M_RUN) break;
                r = int'($urandom_range(99));
                set_in($urandom_range(1), ($urandom_range(99) < 20),
                       (r < 2), $urandom_range(1),
                       (r >= 2 && r < 22), (r >= 22 && r < 38) || ($urandom_range(99) < 3),
                       $urandom_range(1), int'($urandom_range(MOD - 1)));
                if ($urandom_range(99) < 8) target = PC_W'(MOD - 1);
                cycle($sformatf("r%0d_c%0d", run, c));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
